stopwatch_timer: RTL and testbench

STOPWATCH_TIMER -- requirements
Module: stopwatch_timer

---
 rtl/stopwatch_pkg.sv | 19 +
 rtl/stopwatch_bcd_digit.sv | 43 ++++
 rtl/stopwatch_timer.sv | 138 +++++++++++++
 tb/tb_stopwatch_timer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
// Shared definitions for the stopwatch timer slice.
//   state_t      : FSM state encoding (IDLE / RUN / PAUSE)
//   ONES_MAX     : highest value of a units digit (seconds or minutes)
//   SEC_TENS_MAX : highest value of the seconds tens digit
//   MIN_TENS_MAX : highest value of the minutes tens digit
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam int ONES_MAX     = 9;
  localparam int SEC_TENS_MAX = 5;
  localparam int MIN_TENS_MAX = 5;

endpackage

// File: rtl/stopwatch_bcd_digit.sv
// bcd_digit
// One BCD digit of the stopwatch carry chain.
// Ports:
//   clk   : clock, all state on posedge
//   rst   : synchronous active-high reset, forces value to 0
//   clr   : synchronous clear, forces value to 0
//   inc   : advance this digit by one
//   value : current digit value (W bits)
//   carry : high when an increment rolls this digit back to 0
// Parameters:
//   W   : digit register width
//   MAX : last legal value before rollover
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter int W   = 4,
  parameter int MAX = ONES_MAX
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value,
  output logic         carry
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  // Anything at or beyond MAX rolls over; this also recovers an illegal value
  // on the next increment instead of letting it run on.
  logic at_or_over;
  assign at_or_over = (value >= MAX_V);
  assign carry      = inc && at_or_over;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      value <= '0;
    end else if (inc) begin
      value <= at_or_over ? '0 : value + 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_timer.sv
// stopwatch_timer
// MM:SS stopwatch with run/pause control, lap freeze and rollover handling.
// Ports:
//   clk      : clock, all state on posedge
//   rst      : synchronous active-high reset
//   tick     : one-second count strobe, counted only while running
//   start    : enter or resume RUN
//   stop     : pause counting (beats start)
//   clear    : zero the count and return to IDLE (beats stop and start)
//   lap      : rising edge toggles the frozen display
//   sec_ones, sec_tens, min_ones, min_tens : displayed BCD digits
//   running  : high while in RUN
//   frozen   : high while the display shows the lap snapshot
//   wrap     : one-cycle pulse on 59:59 -> 00:00
// Parameters:
//   WRAP_EN  : 1 = wrap at 59:59, 0 = saturate at 59:59 and pause
module stopwatch_timer
  import stopwatch_pkg::*;
#(
  parameter bit WRAP_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] sec_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [2:0] min_tens,
  output logic       running,
  output logic       frozen,
  output logic       wrap
);

  state_t     state;
  logic       lap_q;
  logic [3:0] live_so, live_mo, snap_so, snap_mo;
  logic [2:0] live_st, live_mt, snap_st, snap_mt;
  logic       c_so, c_st, c_mo, c_mt;

  // A tick only counts in RUN, and a simultaneous clear or stop swallows it.
  logic count_en;
  assign count_en = (state == RUN) && tick && !clear && !stop;

  logic at_max;
  assign at_max = (live_so == 4'(ONES_MAX))     && (live_st == 3'(SEC_TENS_MAX)) &&
                  (live_mo == 4'(ONES_MAX))     && (live_mt == 3'(MIN_TENS_MAX));

  // In saturating mode the tick at 59:59 is absorbed and the FSM pauses.
  logic sat_hit;
  assign sat_hit = count_en && at_max && !WRAP_EN;

  logic inc_first;
  assign inc_first = count_en && !sat_hit;

  logic lap_rise;
  assign lap_rise = lap && !lap_q;

  bcd_digit #(.W(4), .MAX(ONES_MAX)) u_sec_ones (
    .clk(clk), .rst(rst), .clr(clear), .inc(inc_first), .value(live_so), .carry(c_so)
  );
  bcd_digit #(.W(3), .MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk(clk), .rst(rst), .clr(clear), .inc(c_so), .value(live_st), .carry(c_st)
  );
  bcd_digit #(.W(4), .MAX(ONES_MAX)) u_min_ones (
    .clk(clk), .rst(rst), .clr(clear), .inc(c_st), .value(live_mo), .carry(c_mo)
  );
  bcd_digit #(.W(3), .MAX(MIN_TENS_MAX)) u_min_tens (
    .clk(clk), .rst(rst), .clr(clear), .inc(c_mo), .value(live_mt), .carry(c_mt)
  );

  // Control FSM plus lap handling. The top digit only carries out when the
  // whole count rolls 59:59 -> 00:00, so its carry registered is the wrap pulse.
  // The snapshot takes the count held in the digits at the lap edge, i.e. before
  // any tick landing on that same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      running <= 1'b0;
      frozen  <= 1'b0;
      wrap    <= 1'b0;
      lap_q   <= 1'b0;
      snap_so <= '0;
      snap_st <= '0;
      snap_mo <= '0;
      snap_mt <= '0;
    end else begin
      wrap  <= c_mt;
      lap_q <= lap;

      if (clear) begin
        state   <= IDLE;
        running <= 1'b0;
      end else begin
        case (state)
          IDLE, PAUSE: begin
            if (!stop && start) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          RUN: begin
            if (stop || sat_hit) begin
              state   <= PAUSE;
              running <= 1'b0;
            end
          end
          default: begin
            state   <= IDLE;
            running <= 1'b0;
          end
        endcase
      end

      if (clear) begin
        frozen <= 1'b0;
      end else if (lap_rise) begin
        frozen <= !frozen;
        if (!frozen) begin
          snap_so <= live_so;
          snap_st <= live_st;
          snap_mo <= live_mo;
          snap_mt <= live_mt;
        end
      end
    end
  end

  // Display select: snapshot while frozen, live count otherwise.
  assign sec_ones = frozen ? snap_so : live_so;
  assign sec_tens = frozen ? snap_st : live_st;
  assign min_ones = frozen ? snap_mo : live_mo;
  assign min_tens = frozen ? snap_mt : live_mt;

endmodule

// File: tb/tb_stopwatch_timer.sv
// tb_stopwatch_timer
// Drives a wrapping and a saturating stopwatch from the same inputs and compares
// both against a seconds-based model every cycle, with literal display checks
// for the key scenarios.
module tb_stopwatch_timer;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  logic clk = 1'b0;
  logic rst, tick, start, stop, clear, lap;

  logic [3:0] w_so, w_mo, s_so, s_mo;
  logic [2:0] w_st, w_mt, s_st, s_mt;
  logic       w_run, w_frz, w_wrap, s_run, s_frz, s_wrap;

  int num_compared   = 0;
  int num_mismatched = 0;

  // Model state; index 0 is the wrapping instance, 1 the saturating one.
  int m_secs[2];
  int m_state[2];
  int m_frozen[2];
  int m_snap[2];
  int m_wrap[2];
  int m_prev_lap;

  always #5 clk = ~clk;

  stopwatch_timer #(.WRAP_EN(1'b1)) dut_wrap (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .sec_ones(w_so), .sec_tens(w_st), .min_ones(w_mo), .min_tens(w_mt),
    .running(w_run), .frozen(w_frz), .wrap(w_wrap)
  );

  stopwatch_timer #(.WRAP_EN(1'b0)) dut_sat (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .sec_ones(s_so), .sec_tens(s_st), .min_ones(s_mo), .min_tens(s_mt),
    .running(s_run), .frozen(s_frz), .wrap(s_wrap)
  );

  function automatic logic [15:0] packDigits(input logic [2:0] mt, input logic [3:0] mo,
                                             input logic [2:0] st, input logic [3:0] so);
    return {1'b0, mt, mo, 1'b0, st, so};
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    num_compared++;
    if (act != exp) begin
      num_mismatched++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic checkLiteral(input string name, input logic [15:0] act, input logic [15:0] exp);
    num_compared++;
    if (act !== exp) begin
      num_mismatched++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference behaviour in plain seconds (0..3599) for one instance.
  task automatic modelStep(input int k);
    int  old_secs;
    bit  counts;
    bit  rise;
    old_secs = m_secs[k];
    rise     = lap && (m_prev_lap == 0);
    m_wrap[k] = 0;
    if (rst) begin
      m_secs[k] = 0; m_state[k] = M_IDLE; m_frozen[k] = 0; m_snap[k] = 0;
    end else begin
      counts = (m_state[k] == M_RUN) && tick && !clear && !stop;
      if (clear) begin
        m_secs[k]  = 0;
        m_state[k] = M_IDLE;
      end else begin
        if (stop) begin
          if (m_state[k] == M_RUN) m_state[k] = M_PAUSE;
        end else if (start && m_state[k] != M_RUN) begin
          m_state[k] = M_RUN;
        end
        if (counts) begin
          if (m_secs[k] == 3599) begin
            if (k == 0) begin
              m_secs[k] = 0;
              m_wrap[k] = 1;
            end else begin
              m_state[k] = M_PAUSE;
            end
          end else begin
            m_secs[k] = m_secs[k] + 1;
          end
        end
      end
      if (clear) m_frozen[k] = 0;
      else if (rise) begin
        if (m_frozen[k] == 0) m_snap[k] = old_secs;
        m_frozen[k] = (m_frozen[k] == 0) ? 1 : 0;
      end
    end
  endtask

  task automatic checkOutput();
    int disp;
    for (int k = 0; k < 2; k++) begin
      disp = m_frozen[k] ? m_snap[k] : m_secs[k];
      if (k == 0) begin
        cmp("w.sec_ones", int'(w_so), (disp % 60) % 10);
        cmp("w.sec_tens", int'(w_st), (disp % 60) / 10);
        cmp("w.min_ones", int'(w_mo), (disp / 60) % 10);
        cmp("w.min_tens", int'(w_mt), disp / 600);
        cmp("w.running",  int'(w_run), (m_state[k] == M_RUN) ? 1 : 0);
        cmp("w.frozen",   int'(w_frz), m_frozen[k]);
        cmp("w.wrap",     int'(w_wrap), m_wrap[k]);
      end else begin
        cmp("s.sec_ones", int'(s_so), (disp % 60) % 10);
        cmp("s.sec_tens", int'(s_st), (disp % 60) / 10);
        cmp("s.min_ones", int'(s_mo), (disp / 60) % 10);
        cmp("s.min_tens", int'(s_mt), disp / 600);
        cmp("s.running",  int'(s_run), (m_state[k] == M_RUN) ? 1 : 0);
        cmp("s.frozen",   int'(s_frz), m_frozen[k]);
        cmp("s.wrap",     int'(s_wrap), m_wrap[k]);
      end
    end
  endtask

  // One clock: drive on the falling edge, advance the model at the rising
  // edge, compare shortly after it.
  task automatic applyStimulus(input logic r, input logic s, input logic p,
                               input logic c, input logic l, input logic t);
    @(negedge clk);
    rst = r; start = s; stop = p; clear = c; lap = l; tick = t;
    @(posedge clk);
    modelStep(0);
    modelStep(1);
    m_prev_lap = r ? 0 : int'(l);
    #1;
    checkOutput();
  endtask

  task automatic runTicks(input int n, input logic l);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, l, 1'b1);
  endtask

  logic lap_lvl;

  initial begin
    rst = 1'b1; tick = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_secs[k] = 0; m_state[k] = M_IDLE; m_frozen[k] = 0; m_snap[k] = 0; m_wrap[k] = 0;
    end
    m_prev_lap = 0;

    // Reset wins over start and tick.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkLiteral("reset_display", packDigits(w_mt, w_mo, w_st, w_so), 16'h0000);
    checkLiteral("reset_flags", {13'd0, w_run, w_frz, w_wrap}, 16'h0000);

    // Start then 75 ticks gives 01:15.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    runTicks(75, 1'b0);
    checkLiteral("ticks75", packDigits(w_mt, w_mo, w_st, w_so), 16'h0115);

    // Carry boundaries up to 59:59 and the rollover behaviour of both builds.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    runTicks(9, 1'b0);
    checkLiteral("at_0009", packDigits(w_mt, w_mo, w_st, w_so), 16'h0009);
    runTicks(1, 1'b0);
    checkLiteral("carry_0010", packDigits(w_mt, w_mo, w_st, w_so), 16'h0010);
    runTicks(49, 1'b0);
    checkLiteral("at_0059", packDigits(w_mt, w_mo, w_st, w_so), 16'h0059);
    runTicks(1, 1'b0);
    checkLiteral("carry_0100", packDigits(w_mt, w_mo, w_st, w_so), 16'h0100);
    runTicks(539, 1'b0);
    checkLiteral("at_0959", packDigits(w_mt, w_mo, w_st, w_so), 16'h0959);
    runTicks(1, 1'b0);
    checkLiteral("carry_1000", packDigits(w_mt, w_mo, w_st, w_so), 16'h1000);
    runTicks(2999, 1'b0);
    checkLiteral("w_at_5959", packDigits(w_mt, w_mo, w_st, w_so), 16'h5959);
    checkLiteral("s_at_5959", packDigits(s_mt, s_mo, s_st, s_so), 16'h5959);
    runTicks(1, 1'b0);
    checkLiteral("w_wrapped", packDigits(w_mt, w_mo, w_st, w_so), 16'h0000);
    checkLiteral("w_wrap_flags", {13'd0, w_run, w_frz, w_wrap}, 16'h0005);
    checkLiteral("s_saturated", packDigits(s_mt, s_mo, s_st, s_so), 16'h5959);
    checkLiteral("s_sat_flags", {13'd0, s_run, s_frz, s_wrap}, 16'h0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkLiteral("w_wrap_one_cycle", {15'd0, w_wrap}, 16'h0000);

    // Stop beats a simultaneous tick; paused ticks ignored; resume counts on.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    runTicks(5, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkLiteral("stop_with_tick", packDigits(w_mt, w_mo, w_st, w_so), 16'h0005);
    runTicks(3, 1'b0);
    checkLiteral("paused_ticks", packDigits(w_mt, w_mo, w_st, w_so), 16'h0005);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    runTicks(1, 1'b0);
    checkLiteral("resume_0006", packDigits(w_mt, w_mo, w_st, w_so), 16'h0006);

    // Lap freeze holds 00:20 while live count runs to 00:30.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    runTicks(20, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkLiteral("lap_freeze", {w_frz, packDigits(w_mt, w_mo, w_st, w_so)}, {1'b1, 16'h0020});
    runTicks(10, 1'b1);
    checkLiteral("lap_held", packDigits(w_mt, w_mo, w_st, w_so), 16'h0020);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkLiteral("lap_release", {w_frz, packDigits(w_mt, w_mo, w_st, w_so)}, {1'b0, 16'h0030});

    // All three commands together while frozen at 02:00: clear wins.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    runTicks(120, 1'b0);
    checkLiteral("at_0200", packDigits(w_mt, w_mo, w_st, w_so), 16'h0200);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checkLiteral("all_cmds", {w_run, w_frz, packDigits(w_mt, w_mo, w_st, w_so)}, {2'b00, 16'h0000});

    // Reset in the middle of counting discards the count.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    runTicks(30, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkLiteral("mid_reset", {w_run, packDigits(w_mt, w_mo, w_st, w_so)}, {1'b0, 16'h0000});

    // Random traffic against the model.
    lap_lvl = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) lap_lvl = ~lap_lvl;
      applyStimulus(($urandom_range(0, 299) == 0),
                    ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 14) == 0),
                    ($urandom_range(0, 59) == 0),
                    lap_lvl,
                    ($urandom_range(0, 1) == 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
